regfile_wb_arbiter: RTL

// - Shares one register-file write port among NumReq result producers (ALU, FPU, load unit, ...).
// - Arbitration is round-robin, with a valid/ready handshake per requester.
// - The winning write is registered: one write per cycle reaches the register file one cycle after acceptance.
// - Sits between the execute/writeback units and the integer or FP register file; one instance per file.

---
 rtl/regfile_wb_arbiter_pkg.sv | 23 ++
 rtl/regfile_wb_arbiter_rr_priority_picker.sv | 38 +++
 rtl/regfile_wb_arbiter.sv | 90 +++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// wb_pkg: shared constants and types for the register-file writeback arbiter.
//   WB_SIZE / WB_ADDR_W : default write-data and register-index widths
//   wb_req_t            : one producer's write request (index + data)
//   reg_idx_t           : register index type
//   rr_next()           : round-robin pointer successor with wrap-around
package wb_pkg;

  localparam int unsigned WB_SIZE   = 64;
  localparam int unsigned WB_ADDR_W = 5;

  typedef logic [WB_ADDR_W-1:0] reg_idx_t;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_SIZE-1:0]   data;
  } wb_req_t;

  // Successor of requester index g among n requesters.
  function automatic int unsigned rr_next(input int unsigned g, input int unsigned n);
    return (g == n - 1) ? 0 : g + 1;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_priority_picker.sv
// rr_priority_picker: combinational round-robin selector.
//   req   [N-1:0]    : request vector
//   ptr   [IdxW-1:0] : highest-priority index (must be < N)
//   grant [N-1:0]    : one-hot grant, zero when no request
//   idx   [IdxW-1:0] : encoded index of the granted request (0 when none)
//   any              : at least one request present
module rr_priority_picker
  import wb_pkg::*;
#(
  parameter int unsigned N    = 2,
  parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [IdxW-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [IdxW-1:0] idx,
  output logic            any
);

  always_comb begin
    int unsigned j;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    // Scan N positions starting at ptr, wrapping; first hit wins.
    for (int unsigned i = 0; i < N; i++) begin
      j = 32'(ptr) + i;
      if (j >= N) j = j - N;
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = IdxW'(j);
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares one register-file write port among NumReq
// producers with round-robin arbitration and a registered write.
//   clk          : clock, rising edge
//   reset        : asynchronous, active-low reset
//   stall_i      : register file cannot accept a write; no grants
//   req_valid_i  : per-requester write present
//   req_addr_i   : packed destination indices, slice i = [i*AddrWidth +: AddrWidth]
//   req_data_i   : packed write data, slice i = [i*Size +: Size]
//   req_ready_o  : one-hot (or zero) acceptance this cycle
//   we_o/waddr_o/wdata_o : registered register-file write, one cycle after accept
//   grant_id_o   : requester that produced the current write
module regfile_wb_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned Size      = WB_SIZE,
  parameter int unsigned AddrWidth = WB_ADDR_W,
  parameter int unsigned NumReq    = 2,
  parameter bit          ZeroReg   = 1'b1,
  localparam int unsigned IdxW     = $clog2(NumReq)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        stall_i,
  input  logic [NumReq-1:0]           req_valid_i,
  input  logic [NumReq*AddrWidth-1:0] req_addr_i,
  input  logic [NumReq*Size-1:0]      req_data_i,
  output logic [NumReq-1:0]           req_ready_o,
  output logic                        we_o,
  output logic [AddrWidth-1:0]        waddr_o,
  output logic [Size-1:0]             wdata_o,
  output logic [IdxW-1:0]             grant_id_o
);

  typedef struct packed {
    logic [AddrWidth-1:0] addr;
    logic [Size-1:0]      data;
  } req_t;

  logic [IdxW-1:0]   rr_q;
  logic [NumReq-1:0] pick_grant;
  logic [IdxW-1:0]   pick_idx;
  logic              pick_any;
  logic              accept;
  req_t              win;

  rr_priority_picker #(
    .N    (NumReq),
    .IdxW (IdxW)
  ) u_picker (
    .req   (req_valid_i),
    .ptr   (rr_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Ready is gated by reset so producers never retire while the arbiter is held.
  assign accept      = reset && !stall_i && pick_any;
  assign req_ready_o = accept ? pick_grant : '0;

  always_comb begin
    win = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (32'(pick_idx) == i) begin
        win.addr = req_addr_i[i*AddrWidth +: AddrWidth];
        win.data = req_data_i[i*Size +: Size];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_q       <= '0;
      we_o       <= 1'b0;
      waddr_o    <= '0;
      wdata_o    <= '0;
      grant_id_o <= '0;
    end else if (accept) begin
      // Writes to x0 are still accepted and advance the pointer, but never reach the file.
      we_o       <= !(ZeroReg && (win.addr == '0));
      waddr_o    <= win.addr;
      wdata_o    <= win.data;
      grant_id_o <= pick_idx;
      rr_q       <= IdxW'(rr_next(32'(pick_idx), NumReq));
    end else begin
      we_o <= 1'b0;
    end
  end

endmodule
